sdr_burst_data_path: RTL and testbench
======================================

# sdr_burst_data_path

Parametrised SDRAM data-path engine for the SDR controller: it carries write and read bursts between the APB-side host data interface and the bidirectional SDRAM DQ/DQM pins. It generalises the single-beat data path to configurable data width, burst length and CAS latency. It adds a prefill write FIFO with a valid/ready handshake, per-byte write masking, pipelined back-to-back reads, and sticky error flags for illegal command sequencing. The command FSM tells the block the cycle in which it launches a WRITE or READ; the block owns all DQ/DQM timing.

## Interface
Parameters:
- DW, 16, data width; must be a multiple of 8.
- BL, 4, burst length; legal values 1, 2, 4, 8.
- CL, 2, CAS latency in clocks; legal values 2, 3.
- DEPTH, 2*BL, write FIFO depth in beats; must be at least BL.

Ports:
- pclk  in  1  system clock; all logic on rising edge.
- preset_n  in  1  asynchronous, active-low reset.
- wr_cmd  in  1  pulse: WRITE command is launched on the SDRAM bus at this edge.
- rd_cmd  in  1  pulse: READ command is launched on the SDRAM bus at this edge.
- wdata  in  DW  host write beat.
- wmask  in  DW/8  byte enables for wdata; 1 = write byte.
- wdata_valid  in  1  host beat valid.
- wdata_ready  out  1  FIFO can accept a beat (level < DEPTH).
- wr_level  out  $clog2(DEPTH+1)  FIFO occupancy.
- wr_burst_rdy  out  1  level ≥ BL; the command FSM issues wr_cmd only when this is high.
- rdata  out  DW  captured read beat.
- rdata_valid  out  1  rdata holds a new beat this cycle.
- wr_busy  out  1  write burst is driving DQ.
- rd_busy  out  1  read beats are pending or in flight.
- err_clr  in  1  clears the sticky error flags.
- cmd_err  out  1  sticky: an illegal command was received and ignored.
- underrun  out  1  sticky: a write burst started with level < BL.
- sdr_dq  inout  DW  SDRAM data bus.
- sdr_dqm  out  DW/8  SDRAM data mask; 1 = masked.

## Operation
- **Write FIFO**
  - Push on wdata_valid && wdata_ready; each entry stores {wmask, wdata}.
  - Pop once per write beat.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo DEPTH.
- **Write burst** (wr_cmd sampled high at edge k, legal):
  - At edges k..k+BL-1, sdr_dq drives the FIFO head and the output enable is asserted.
  - sdr_dqm = ~head mask for each beat.
  - At edge k+BL the output enable drops and sdr_dq returns to high-Z; wr_busy is high over the same window.
  - If the FIFO is empty at any beat: drive DQ = 0 and DQM = all ones, do not pop, and set underrun. The burst still lasts BL beats.
- **Read** (rd_cmd at edge k, legal):
  - Beat i (i = 0..BL-1) is sampled at edge k+CL+i; rdata is updated from sdr_dq and rdata_valid is high after that edge.
  - Tracking uses a valid shift register of length CL+BL, so overlapping reads pipeline.
  - rd_busy = any bit of the shift register set.
  - During reads DQM = 0 and DQ is high-Z.
- **Legality checks**: an illegal command is ignored and sets cmd_err.
  - wr_cmd while wr_busy or rd_busy: illegal (read-to-write turnaround).
  - rd_cmd while wr_busy: illegal.
  - rd_cmd fewer than BL cycles after the previous accepted rd_cmd: illegal.
  - wr_cmd and rd_cmd in the same cycle: both ignored, cmd_err set.
- **Error flags**: err_clr clears cmd_err and underrun at the next edge. A new error in the same cycle as err_clr wins, so the flag stays set.
- **Reset** (preset_n low, asynchronous):
  - FIFO emptied: level 0, wdata_ready = 1, wr_burst_rdy = 0.
  - sdr_dq high-Z, sdr_dqm all ones, rdata 0, rdata_valid 0.
  - wr_busy, rd_busy, cmd_err and underrun all 0.
  - Reset mid-burst aborts the burst immediately; no further beats are driven.
- **Idle**: after the first clock out of reset, sdr_dqm is 0 whenever no write beat is active.

## Timing
- DQ, DQM, rdata and rdata_valid are all registered; no combinational path from any input to the pins.
- wdata_ready and wr_burst_rdy are derived from the registered level only.
- Write data is coincident with the command edge; the first beat appears at the same edge as WRITE.
- Read latency from rd_cmd to the first rdata_valid edge is CL.
- Back-to-back reads every BL cycles give a continuous rdata_valid stream.
- A rd_cmd is legal at the edge immediately after the last write beat, i.e. edge k+BL.

## Test plan
- **Write burst**: DW=16, BL=4. Push 0x1111, 0x2222, 0x3333, 0x4444 with wmask 2'b11 except beat 2 = 2'b01, then pulse wr_cmd.
  - Expect DQ 1111/2222/3333/4444 on 4 consecutive edges, DQM 00,00,10,00, then high-Z, and level 0.
- **Read pipeline**: CL=2. Pulse rd_cmd at edges 0 and 4; the bench drives DQ 0xA0+n at each edge.
  - Expect rdata_valid high for 8 consecutive cycles starting at edge 2, with data matching DQ sampled at edges 2..9.
- **Underrun**: push 2 beats, then wr_cmd.
  - Expect beats 0–1 driven, beats 2–3 with DQM 11, underrun=1; after err_clr, underrun=0.
- **Illegal sequencing**: wr_cmd while rd_busy; rd_cmd 2 cycles after a rd_cmd with BL=4; wr_cmd and rd_cmd together.
  - Expect each ignored, DQ untouched, cmd_err=1.
- **FIFO full/wrap**: DEPTH=8. Push 8 beats.
  - Expect wdata_ready=0; push during burst pop keeps level steady; 3 bursts verify pointer wrap and data order.
- **Reset mid-burst**: assert preset_n=0 at beat 1.
  - Expect DQ high-Z, DQM all ones and all flags 0 immediately; level 0 after release.

Source files
------------

// File: rtl/sdr_burst_data_path.sv
// sdr_burst_data_path: prefill write FIFO plus SDRAM DQ/DQM burst driver and CL-delayed read capture.
// Latency: write beat 0 is on DQ at the WRITE edge; read beat i is captured CL+i edges after READ.
// Backpressure: wdata_ready drops when the FIFO holds DEPTH beats; wr_burst_rdy gates WRITE issue.
//
// Ports:
//   pclk, preset_n            clock, async active-low reset
//   wr_cmd, rd_cmd            WRITE/READ launched on the SDRAM bus at this edge
//   wdata, wmask, wdata_valid host write beat, byte enables, valid; wdata_ready is the ready
//   wr_level, wr_burst_rdy    FIFO occupancy, occupancy >= BL
//   rdata, rdata_valid        captured read beat
//   wr_busy, rd_busy          write burst on DQ, read beats pending
//   err_clr, cmd_err, underrun  sticky error flags and their clear
//   sdr_dq, sdr_dqm           SDRAM data bus and data mask (1 = masked)

// Small circular FIFO; head_dat shows the oldest entry, pops must only occur when level != 0.
module sdr_burst_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int LW   = $clog2(DEPTH + 1)
) (
  input  logic          pclk,
  input  logic          preset_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head_dat,
  output logic [LW-1:0] level
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) wptr <= (wptr == AW'(DEPTH - 1)) ? '0 : wptr + AW'(1);
      if (pop)  rptr <= (rptr == AW'(DEPTH - 1)) ? '0 : rptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (push) mem[wptr] <= push_dat;
  end

  assign head_dat = mem[rptr];
endmodule

module sdr_burst_data_path #(
  parameter int DW    = 16,
  parameter int BL    = 4,
  parameter int CL    = 2,
  parameter int DEPTH = 2 * BL
) (
  input  logic                       pclk,
  input  logic                       preset_n,
  input  logic                       wr_cmd,
  input  logic                       rd_cmd,
  input  logic [DW-1:0]              wdata,
  input  logic [DW/8-1:0]            wmask,
  input  logic                       wdata_valid,
  output logic                       wdata_ready,
  output logic [$clog2(DEPTH+1)-1:0] wr_level,
  output logic                       wr_burst_rdy,
  output logic [DW-1:0]              rdata,
  output logic                       rdata_valid,
  output logic                       wr_busy,
  output logic                       rd_busy,
  input  logic                       err_clr,
  output logic                       cmd_err,
  output logic                       underrun,
  inout  wire  [DW-1:0]              sdr_dq,
  output logic [DW/8-1:0]            sdr_dqm
);
  localparam int MW  = DW / 8;
  localparam int LW  = $clog2(DEPTH + 1);
  localparam int RW  = $clog2(BL + 1);
  localparam int SRW = CL + BL;
  // A READ at edge k sets the bits that reach position 0 just before edges k+CL .. k+CL+BL-1.
  localparam logic [SRW-1:0] RD_MASK = SRW'(((1 << BL) - 1) << (CL - 1));

  logic [MW+DW-1:0] head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             head_ok;
  logic             wr_tail;
  logic             wr_go;
  logic             rd_go;
  logic             cmd_bad;
  logic             beat;
  logic             dq_oe;
  logic [DW-1:0]    dq_q;
  logic [RW-1:0]    wr_rem;
  logic [RW-1:0]    rd_hold;
  logic [SRW-1:0]   rd_sr;

  sdr_burst_fifo #(.W(MW + DW), .DEPTH(DEPTH)) u_wfifo (
    .pclk     (pclk),
    .preset_n (preset_n),
    .push     (fifo_push),
    .push_dat ({wmask, wdata}),
    .pop      (fifo_pop),
    .head_dat (head),
    .level    (wr_level)
  );

  assign wdata_ready  = wr_level < LW'(DEPTH);
  assign wr_burst_rdy = wr_level >= LW'(BL);
  assign fifo_push    = wdata_valid && wdata_ready;
  assign head_ok      = wr_level != '0;

  // Only beats still to come block a READ, so a READ on the edge that ends the burst is legal.
  assign wr_tail  = dq_oe && (wr_rem != '0);
  assign wr_go    = wr_cmd && !rd_cmd && !dq_oe && !rd_busy;
  assign rd_go    = rd_cmd && !wr_cmd && !wr_tail && (rd_hold == '0);
  assign cmd_bad  = (wr_cmd || rd_cmd) && !wr_go && !rd_go;
  assign beat     = wr_go || wr_tail;
  assign fifo_pop = beat && head_ok;

  assign wr_busy = dq_oe;
  assign rd_busy = |rd_sr;
  assign sdr_dq  = dq_oe ? dq_q : 'z;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      dq_oe       <= 1'b0;
      dq_q        <= '0;
      sdr_dqm     <= '1;
      wr_rem      <= '0;
      rd_sr       <= '0;
      rd_hold     <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      cmd_err     <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      // Write burst: dq_oe is high exactly while beats are on the bus.
      dq_oe <= beat;
      if (wr_go)        wr_rem <= RW'(BL - 1);
      else if (wr_tail) wr_rem <= wr_rem - RW'(1);

      if (beat) begin
        // An empty FIFO still consumes a beat slot, driven as a fully masked zero.
        dq_q    <= head_ok ? head[DW-1:0] : '0;
        sdr_dqm <= head_ok ? ~head[DW +: MW] : '1;
      end else begin
        sdr_dqm <= '0;
      end

      // Read tracking: overlapping READs merge into the same shift register.
      rd_sr <= (rd_sr >> 1) | (rd_go ? RD_MASK : '0);
      if (rd_go)                rd_hold <= RW'(BL - 1);
      else if (rd_hold != '0)   rd_hold <= rd_hold - RW'(1);

      rdata_valid <= rd_sr[0];
      if (rd_sr[0]) rdata <= sdr_dq;

      // A new error in the clearing cycle wins.
      cmd_err  <= (cmd_err && !err_clr) || cmd_bad;
      underrun <= (underrun && !err_clr) || (beat && !head_ok) ||
                  (wr_go && (wr_level < LW'(BL)));
    end
  end
endmodule

// File: tb/tb_sdr_burst_data_path.sv
module tb_sdr_burst_data_path;
  localparam int DW    = 16;
  localparam int BL    = 4;
  localparam int CL    = 2;
  localparam int DEPTH = 8;
  localparam int MW    = DW / 8;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          pclk;
  logic          preset_n;
  logic          wr_cmd;
  logic          rd_cmd;
  logic [DW-1:0] wdata;
  logic [MW-1:0] wmask;
  logic          wdata_valid;
  logic          wdata_ready;
  logic [LW-1:0] wr_level;
  logic          wr_burst_rdy;
  logic [DW-1:0] rdata;
  logic          rdata_valid;
  logic          wr_busy;
  logic          rd_busy;
  logic          err_clr;
  logic          cmd_err;
  logic          underrun;
  wire  [DW-1:0] sdr_dq;
  logic [MW-1:0] sdr_dqm;

  logic          tb_drv;
  logic [DW-1:0] tb_dq;
  assign sdr_dq = tb_drv ? tb_dq : 'z;

  int errors;
  int checks;

  logic [DW+MW-1:0] wq [$];
  logic [DW-1:0]    rq [$];

  sdr_burst_data_path #(.DW(DW), .BL(BL), .CL(CL), .DEPTH(DEPTH)) dut (
    .pclk         (pclk),
    .preset_n     (preset_n),
    .wr_cmd       (wr_cmd),
    .rd_cmd       (rd_cmd),
    .wdata        (wdata),
    .wmask        (wmask),
    .wdata_valid  (wdata_valid),
    .wdata_ready  (wdata_ready),
    .wr_level     (wr_level),
    .wr_burst_rdy (wr_burst_rdy),
    .rdata        (rdata),
    .rdata_valid  (rdata_valid),
    .wr_busy      (wr_busy),
    .rd_busy      (rd_busy),
    .err_clr      (err_clr),
    .cmd_err      (cmd_err),
    .underrun     (underrun),
    .sdr_dq       (sdr_dq),
    .sdr_dqm      (sdr_dqm)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every driven write beat and every read beat is matched against the queues.
  always @(negedge pclk) begin
    if (preset_n) begin
      if (dut.dq_oe) begin
        checks++;
        if (wq.size() == 0) begin
          errors++;
          $display("FAIL wbeat_unexpected: got dq=%h dqm=%b, expected no beat", sdr_dq, sdr_dqm);
        end else begin
          chk("wbeat_dq_dqm", 32'({sdr_dq, sdr_dqm}), 32'(wq.pop_front()));
        end
      end
      if (rdata_valid) begin
        checks++;
        if (rq.size() == 0) begin
          errors++;
          $display("FAIL rbeat_unexpected: got rdata=%h, expected no beat", rdata);
        end else begin
          chk("rbeat_data", 32'(rdata), 32'(rq.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic [MW-1:0] m);
    wdata       = d;
    wmask       = m;
    wdata_valid = 1'b1;
    tick();
    wdata_valid = 1'b0;
  endtask

  task automatic wr_burst();
    wr_cmd = 1'b1;
    tick();
    wr_cmd = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_level"},    32'(wr_level), 32'd0);
    chk({tag, "_wready"},   32'(wdata_ready), 32'd1);
    chk({tag, "_burstrdy"}, 32'(wr_burst_rdy), 32'd0);
    chk({tag, "_dqm"},      32'(sdr_dqm), 32'h3);
    chk({tag, "_oe"},       32'(dut.dq_oe), 32'd0);
    chk({tag, "_rdata"},    32'(rdata), 32'd0);
    chk({tag, "_rvalid"},   32'(rdata_valid), 32'd0);
    chk({tag, "_wbusy"},    32'(wr_busy), 32'd0);
    chk({tag, "_rbusy"},    32'(rd_busy), 32'd0);
    chk({tag, "_cmderr"},   32'(cmd_err), 32'd0);
    chk({tag, "_underrun"}, 32'(underrun), 32'd0);
  endtask

  initial begin
    errors = 0; checks = 0;
    preset_n = 1'b1; wr_cmd = 1'b0; rd_cmd = 1'b0; wdata = '0; wmask = '0;
    wdata_valid = 1'b0; err_clr = 1'b0; tb_drv = 1'b0; tb_dq = '0;

    // Reset state
    #2 preset_n = 1'b0;
    #1 rst_checks("reset");
    tick();
    preset_n = 1'b1;
    tick();
    chk("idle_dqm", 32'(sdr_dqm), 32'd0);

    // Write burst with a masked byte on beat 2
    push_beat(16'h1111, 2'b11);
    push_beat(16'h2222, 2'b11);
    push_beat(16'h3333, 2'b01);
    push_beat(16'h4444, 2'b11);
    chk("wr_level4", 32'(wr_level), 32'd4);
    chk("wr_burst_rdy", 32'(wr_burst_rdy), 32'd1);
    wq.push_back({16'h1111, 2'b00});
    wq.push_back({16'h2222, 2'b00});
    wq.push_back({16'h3333, 2'b10});
    wq.push_back({16'h4444, 2'b00});
    wr_burst();
    chk("wr_busy_on", 32'(wr_busy), 32'd1);
    repeat (4) tick();
    chk("wr_busy_off", 32'(wr_busy), 32'd0);
    chk("wr_oe_off", 32'(dut.dq_oe), 32'd0);
    chk("wr_level0", 32'(wr_level), 32'd0);
    chk("wr_dqm_idle", 32'(sdr_dqm), 32'd0);

    // Pipelined reads at edges 0 and 4; DQ = 0xA0+n before edge n
    for (int n = 2; n <= 9; n++) rq.push_back(DW'(32'hA0 + n));
    tb_drv = 1'b1;
    for (int n = 0; n < 12; n++) begin
      rd_cmd = (n == 0) || (n == 4);
      tb_dq  = DW'(32'hA0 + n);
      tick();
      if (n == 0) chk("rd_busy_on", 32'(rd_busy), 32'd1);
      if (n == 1) chk("rd_not_yet", 32'(rdata_valid), 32'd0);
      if (n == 5) chk("rd_dqm0", 32'(sdr_dqm), 32'd0);
    end
    rd_cmd = 1'b0;
    tb_drv = 1'b0;
    chk("rd_b2b_cmderr", 32'(cmd_err), 32'd0);
    chk("rd_busy_off", 32'(rd_busy), 32'd0);

    // Illegal: WRITE while read pending
    for (int i = 0; i < 4; i++) push_beat(DW'(32'h5000 + i), 2'b11);
    for (int i = 0; i < 4; i++) rq.push_back(16'h5A5A);
    tb_drv = 1'b1; tb_dq = 16'h5A5A;
    rd_cmd = 1'b1; tick(); rd_cmd = 1'b0;
    wr_cmd = 1'b1; tick(); wr_cmd = 1'b0;
    chk("ill_wr_cmderr", 32'(cmd_err), 32'd1);
    chk("ill_wr_busy", 32'(wr_busy), 32'd0);
    chk("ill_wr_level", 32'(wr_level), 32'd4);
    repeat (6) tick();
    pulse_clr();
    chk("ill_wr_clr", 32'(cmd_err), 32'd0);

    // Illegal: READ two cycles after READ
    for (int i = 0; i < 4; i++) rq.push_back(16'h5A5A);
    rd_cmd = 1'b1; tick(); rd_cmd = 1'b0;
    tick();
    rd_cmd = 1'b1; tick(); rd_cmd = 1'b0;
    chk("ill_rd_cmderr", 32'(cmd_err), 32'd1);
    repeat (6) tick();
    tb_drv = 1'b0;
    chk("ill_rd_busy_off", 32'(rd_busy), 32'd0);

    // Illegal: WRITE and READ together, coinciding with err_clr
    err_clr = 1'b1; wr_cmd = 1'b1; rd_cmd = 1'b1;
    tick();
    err_clr = 1'b0; wr_cmd = 1'b0; rd_cmd = 1'b0;
    chk("ill_both_cmderr", 32'(cmd_err), 32'd1);
    chk("ill_both_rbusy", 32'(rd_busy), 32'd0);
    chk("ill_both_wbusy", 32'(wr_busy), 32'd0);
    chk("ill_both_level", 32'(wr_level), 32'd4);
    pulse_clr();
    chk("ill_both_clr", 32'(cmd_err), 32'd0);

    // READ at the edge the write burst ends is legal
    for (int i = 0; i < 4; i++) wq.push_back({DW'(32'h5000 + i), 2'b00});
    for (int i = 0; i < 4; i++) rq.push_back(16'hC3C3);
    wr_burst();
    repeat (3) tick();
    rd_cmd = 1'b1; tick(); rd_cmd = 1'b0;
    tb_drv = 1'b1; tb_dq = 16'hC3C3;
    chk("wr2rd_cmderr", 32'(cmd_err), 32'd0);
    repeat (6) tick();
    tb_drv = 1'b0;
    chk("wr2rd_rbusy_off", 32'(rd_busy), 32'd0);
    chk("wr2rd_level", 32'(wr_level), 32'd0);

    // Underrun: two beats queued, four-beat burst
    push_beat(16'hAAAA, 2'b11);
    push_beat(16'hBBBB, 2'b10);
    chk("ur_burstrdy", 32'(wr_burst_rdy), 32'd0);
    wq.push_back({16'hAAAA, 2'b00});
    wq.push_back({16'hBBBB, 2'b01});
    wq.push_back({16'h0000, 2'b11});
    wq.push_back({16'h0000, 2'b11});
    wr_burst();
    repeat (4) tick();
    chk("ur_flag", 32'(underrun), 32'd1);
    chk("ur_level", 32'(wr_level), 32'd0);
    pulse_clr();
    chk("ur_clr", 32'(underrun), 32'd0);

    // FIFO full, steady level under push+pop, pointer wrap over three bursts
    for (int i = 0; i < 12; i++) wq.push_back({DW'(32'h100 + i), ~MW'(i)});
    for (int i = 0; i < 8; i++) push_beat(DW'(32'h100 + i), MW'(i));
    chk("full_level", 32'(wr_level), 32'd8);
    chk("full_wready", 32'(wdata_ready), 32'd0);
    push_beat(16'hDEAD, 2'b11);
    chk("full_nopush", 32'(wr_level), 32'd8);
    wr_burst();
    repeat (4) tick();
    chk("wrap_b1_level", 32'(wr_level), 32'd4);
    wr_cmd = 1'b1;
    for (int i = 8; i < 12; i++) begin
      wdata = DW'(32'h100 + i); wmask = MW'(i); wdata_valid = 1'b1;
      tick();
      wr_cmd = 1'b0;
      chk("wrap_steady_level", 32'(wr_level), 32'd4);
    end
    wdata_valid = 1'b0;
    tick();
    wr_burst();
    repeat (4) tick();
    chk("wrap_b3_level", 32'(wr_level), 32'd0);

    // Reset in the middle of a burst, with cmd_err set beforehand
    wr_cmd = 1'b1; rd_cmd = 1'b1; tick(); wr_cmd = 1'b0; rd_cmd = 1'b0;
    chk("pre_rst_cmderr", 32'(cmd_err), 32'd1);
    for (int i = 0; i < 4; i++) push_beat(DW'(32'h7000 + i), 2'b11);
    wq.push_back({16'h7000, 2'b00});
    wr_burst();
    tick();
    preset_n = 1'b0;
    #1 rst_checks("midrst");
    tick();
    preset_n = 1'b1;
    repeat (3) tick();
    chk("post_rst_level", 32'(wr_level), 32'd0);
    chk("post_rst_oe", 32'(dut.dq_oe), 32'd0);
    chk("post_rst_dqm", 32'(sdr_dqm), 32'd0);

    chk("wq_drained", 32'(wq.size()), 32'd0);
    chk("rq_drained", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
